// File: rtl/prog_clk_div_pkg.sv
// Shared constants and types for prog_clk_div.
// Square outputs are built only with `define PROG_CLK_DIV_SQUARE_EN.
package prog_clk_div_pkg;

   localparam int unsigned DIV_W         = 16;
   localparam int unsigned DEFAULT_DIV_C = 10;

   typedef logic [DIV_W-1:0] div_t;

   // Channel-index width, never narrower than one bit
   function automatic int unsigned chan_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prog_clk_div_chan.sv
// One divider channel: counter, active/pending divisor, tick and optional square output.
// Square output is built only with `define PROG_CLK_DIV_SQUARE_EN.
module prog_clk_div_chan
   import prog_clk_div_pkg::*;
#(
   parameter int unsigned WIDTH       = DIV_W,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic             clk_in,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_div,
   output logic             o_pend,
   output logic             o_tick,
   output logic             o_sq
);

   localparam logic [WIDTH-1:0] C_DEF = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] r_cnt, r_div_act, r_div_pend;
   logic             r_pend, r_tick;

   logic [WIDTH-1:0] w_cnt_nxt, w_act_nxt, w_pdiv_nxt;
   logic             w_pend_nxt, w_tick_nxt, w_wrap;

   assign w_wrap = (r_cnt == r_div_act - WIDTH'(1));

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_act_nxt  = r_div_act;
      w_pdiv_nxt = r_div_pend;
      w_pend_nxt = r_pend;
      w_tick_nxt = 1'b0;
      if (i_sync) begin
         w_cnt_nxt = '0;
         if (r_pend) begin
            w_act_nxt  = r_div_pend;
            w_pend_nxt = 1'b0;
         end
      end else if (i_en) begin
         if (w_wrap) begin
            w_cnt_nxt  = '0;
            w_tick_nxt = 1'b1;
            if (r_pend) begin
               w_act_nxt  = r_div_pend;
               w_pend_nxt = 1'b0;
            end
         end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
         end
      end else if (r_pend) begin
         // Idle channel adopts the new divisor at once; restart if the held count no longer fits
         w_act_nxt  = r_div_pend;
         w_pend_nxt = 1'b0;
         if (r_cnt >= r_div_pend) w_cnt_nxt = '0;
      end
      // Top only issues a write when nothing is pending here
      if (i_wr) begin
         w_pdiv_nxt = i_wr_div;
         w_pend_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_div_act  <= C_DEF;
         r_div_pend <= C_DEF;
         r_pend     <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_div_act  <= w_act_nxt;
         r_div_pend <= w_pdiv_nxt;
         r_pend     <= w_pend_nxt;
         r_tick     <= w_tick_nxt;
      end
   end

   assign o_pend = r_pend;
   assign o_tick = r_tick;

`ifdef PROG_CLK_DIV_SQUARE_EN
   logic             r_sq;
   logic [WIDTH:0]   w_half;

   // ceil(div/2) in one extra bit so the maximum divisor cannot overflow
   assign w_half = ({1'b0, w_act_nxt} + (WIDTH+1)'(1)) >> 1;

   always_ff @(posedge clk_in) begin
      if (i_rst)
         r_sq <= 1'b0;
      else if (i_sync || i_en)
         r_sq <= ({1'b0, w_cnt_nxt} < w_half);
   end

   assign o_sq = r_sq;
`else
   assign o_sq = 1'b0;
`endif

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel runtime-programmable clock-enable generator with config handshake.
// Square outputs on clk_out are built only with `define PROG_CLK_DIV_SQUARE_EN.
module prog_clk_div
   import prog_clk_div_pkg::*;
#(
   parameter int unsigned  CHANNELS    = 4,
   parameter int unsigned  WIDTH       = DIV_W,
   parameter int unsigned  DEFAULT_DIV = DEFAULT_DIV_C,
   localparam int unsigned CHAN_W      = chan_w(CHANNELS)
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync_all,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CHAN_W-1:0]   cfg_chan,
   input  logic [WIDTH-1:0]    cfg_div,
   output logic                cfg_err,
   output logic [CHANNELS-1:0] tick_out,
   output logic [CHANNELS-1:0] clk_out
);

   logic [CHANNELS-1:0] w_pend, w_wr, w_sq;
   logic                w_ready, w_accept, w_bad;
   logic                r_cfg_err;

   // Out-of-range channels are always ready so the rejected write can complete
   always_comb begin
      w_ready = 1'b1;
      for (int unsigned i = 0; i < CHANNELS; i++)
         if (cfg_chan == CHAN_W'(i)) w_ready = ~w_pend[i];
   end

   assign cfg_ready = w_ready;
   assign w_accept  = cfg_valid & w_ready;
   assign w_bad     = (cfg_div == '0) || (32'(cfg_chan) >= CHANNELS);

   always_ff @(posedge clk_in) begin
      if (rst) r_cfg_err <= 1'b0;
      else     r_cfg_err <= w_accept & w_bad;
   end

   assign cfg_err = r_cfg_err;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_wr[gi] = w_accept & ~w_bad & (cfg_chan == CHAN_W'(gi));

      prog_clk_div_chan #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk_in   (clk_in),
         .i_rst    (rst),
         .i_en     (en[gi]),
         .i_sync   (sync_all),
         .i_wr     (w_wr[gi]),
         .i_wr_div (cfg_div),
         .o_pend   (w_pend[gi]),
         .o_tick   (tick_out[gi]),
         .o_sq     (w_sq[gi])
      );
   end

   assign clk_out = w_sq;

endmodule
